icache_2way: RTL
================

Name: icache_2way

Overview:
- Instruction cache between the instruction-fetch stage and the memory path.
- Two-way set-associative, one 32-bit instruction per line.
- Fetch issues a read and samples hit/instruction on the next cycle. On a miss, fetch assembles the word byte-by-byte from memctrl and writes it back here as a fill.
- flush_i invalidates all contents, e.g. for fence.i or a debug reset of cache state.

Parameters:
- INDEX_BITS, 6, set-index width (2^INDEX_BITS sets, 2 ways each).
- ADDR_WIDTH, 32, instruction address width.

Ports:
- clk  input  1  system clock, posedge.
- rst  input  1  asynchronous reset, active-low.
- rdy  input  1  global ready; when 0 all state and outputs hold.
- read_i  input  1  read request from fetch.
- read_addr_i  input  ADDR_WIDTH  read address (bits [1:0] ignored).
- write_i  input  1  fill request from fetch.
- write_addr_i  input  ADDR_WIDTH  fill address (bits [1:0] ignored).
- write_inst_i  input  32  fill instruction.
- flush_i  input  1  invalidate all lines.
- read_hit_o  output  1  registered hit result of the previous-cycle read.
- read_inst_o  output  32  registered instruction for the previous-cycle read.

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[ADDR_WIDTH-1:INDEX_BITS+2]
- Per-set storage:
  - valid[1:0], tag0/tag1, data0/data1.
  - lru bit: way to evict next; 0 means way0.
- Data and tag arrays are not reset. valid and lru are.
- Reset (rst=0, asynchronous): all valid=0, all lru=0, read_hit_o=0, read_inst_o=0.
- rdy=0: no array, valid, lru or output changes, regardless of other inputs.
- Read, latency 1. On a posedge with rdy=1, read_i=1, flush_i=0:
  - read_hit_o <= (valid0 & tag0==tag) | (valid1 & tag1==tag).
  - read_inst_o <= data of the matching way.
  - On a hit, lru of that set <= other way.
  - On a miss, read_inst_o <= 0.
- read_i=0 (rdy=1): read_hit_o <= 0, read_inst_o holds.
- Tags never match in both ways. Fill logic guarantees this; a double match is an assertion failure.
- Fill. On a posedge with rdy=1, write_i=1, flush_i=0, victim way is chosen in priority order:
  1. the way already holding the tag (overwrite in place);
  2. else the first invalid way, way0 before way1;
  3. else the way given by lru.
  - Victim way gets valid=1, tag, data=write_inst_i; lru <= other way.
- Read and fill in the same cycle:
  - Same index and same tag: bypass. read_hit_o <= 1 and read_inst_o <= write_inst_i. Fill proceeds.
  - Same index, different tag: read result is computed from pre-fill contents. The fill's lru update wins.
  - Different index: independent.
- Flush (rdy=1, flush_i=1): all valid <= 0, all lru <= 0, read_hit_o <= 0. Any read or write in that cycle is dropped. Flush has priority over read and fill.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous). No pending state survives.
- Index/tag wrap: addresses differing only above the index bits map to the same set and compete via lru.

Test Plan:
1. Reset, then read 0x00000000 -> next cycle read_hit_o=0, read_inst_o=0.
2. Fill 0x00000010 with 0x00500093, then read 0x00000010 -> next cycle read_hit_o=1, read_inst_o=0x00500093.
3. INDEX_BITS=6, conflict and eviction:
   - Fill A=0x00000100 (0x11111111), B=0x00000200 (0x22222222), both index 0, then read A (sets lru to way of B).
   - Fill C=0x00000300 (0x33333333) -> read B misses; reads A and C hit with the correct data.
4. Same-cycle read and fill of 0x00000040 with 0xDEADBEEF on an empty cache -> next cycle read_hit_o=1, read_inst_o=0xDEADBEEF.
5. Flush after test 2, then read 0x00000010 -> miss. A simultaneous fill during the flush cycle is not retained (later read misses).
6. Hold rdy=0 with read_i=1, write_i=1 for 3 cycles -> read_hit_o and read_inst_o unchanged. A subsequent read shows no fill occurred. Asserting rst=0 mid-sequence clears read_hit_o without a clock edge.

Source files
------------

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache, one 32-bit instruction per line.
// Reads return hit/instruction one cycle later; fills come back from fetch after a miss.
module icache_2way #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  read_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [31:0]           write_inst_i,
  input  logic                  flush_i,
  output logic                  read_hit_o,
  output logic [31:0]           read_inst_o
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

  logic [TAG_BITS-1:0] tag0  [SETS];
  logic [TAG_BITS-1:0] tag1  [SETS];
  logic [31:0]         data0 [SETS];
  logic [31:0]         data1 [SETS];
  logic [SETS-1:0]     valid0;
  logic [SETS-1:0]     valid1;
  logic [SETS-1:0]     lru;

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [TAG_BITS-1:0]   wr_tag;
  logic                  rd_hit0;
  logic                  rd_hit1;
  logic                  wr_hit0;
  logic                  wr_hit1;
  logic                  bypass;
  logic                  victim;
  logic                  unused_addr_bits;

  assign rd_idx = read_addr_i[INDEX_BITS+1:2];
  assign wr_idx = write_addr_i[INDEX_BITS+1:2];
  assign rd_tag = read_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign wr_tag = write_addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_addr_bits = ^{read_addr_i[1:0], write_addr_i[1:0]};

  assign rd_hit0 = valid0[rd_idx] && (tag0[rd_idx] == rd_tag);
  assign rd_hit1 = valid1[rd_idx] && (tag1[rd_idx] == rd_tag);
  assign wr_hit0 = valid0[wr_idx] && (tag0[wr_idx] == wr_tag);
  assign wr_hit1 = valid1[wr_idx] && (tag1[wr_idx] == wr_tag);

  // A fill to the line being read in the same cycle forwards the new instruction.
  assign bypass = write_i && (wr_idx == rd_idx) && (wr_tag == rd_tag);

  always_comb begin
    victim = lru[wr_idx];
    if (wr_hit0)              victim = 1'b0;
    else if (wr_hit1)         victim = 1'b1;
    else if (!valid0[wr_idx]) victim = 1'b0;
    else if (!valid1[wr_idx]) victim = 1'b1;
  end

  // The fill's lru update is written last so it overrides a same-set read update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0      <= '0;
      valid1      <= '0;
      lru         <= '0;
      read_hit_o  <= 1'b0;
      read_inst_o <= '0;
    end else if (rdy) begin
      if (flush_i) begin
        valid0     <= '0;
        valid1     <= '0;
        lru        <= '0;
        read_hit_o <= 1'b0;
      end else begin
        if (read_i) begin
          if (bypass) begin
            read_hit_o  <= 1'b1;
            read_inst_o <= write_inst_i;
          end else if (rd_hit0 || rd_hit1) begin
            read_hit_o     <= 1'b1;
            read_inst_o    <= rd_hit1 ? data1[rd_idx] : data0[rd_idx];
            lru[rd_idx]    <= rd_hit0;
          end else begin
            read_hit_o  <= 1'b0;
            read_inst_o <= '0;
          end
        end else begin
          read_hit_o <= 1'b0;
        end
        if (write_i) begin
          if (victim) valid1[wr_idx] <= 1'b1;
          else        valid0[wr_idx] <= 1'b1;
          lru[wr_idx] <= ~victim;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && write_i && !flush_i) begin
      if (victim) begin
        tag1[wr_idx]  <= wr_tag;
        data1[wr_idx] <= write_inst_i;
      end else begin
        tag0[wr_idx]  <= wr_tag;
        data0[wr_idx] <= write_inst_i;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    !(rdy && read_i && rd_hit0 && rd_hit1));

endmodule
